axi4_txn_recorder: RTL and testbench

Passive AXI4 transaction recorder placed directly downstream of the AXI4 monitor tap: snoops the same `axi4_if.monitor` modport and turns individual channel handshakes into one completed-transaction record per read burst and per write response. Records leave on a valid/ready stream for scoreboards or trace dumpers. The block never drives the AXI4 bus.

---
 rtl/axi4_txn_pkg.sv | 34 +++
 rtl/axi4_if.sv | 37 +++
 rtl/axi4_txn_pend_fifo.sv | 52 +++++
 rtl/axi4_txn_recorder.sv | 167 ++++++++++++++++
 tb/tb_axi4_txn_recorder.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_txn_pkg.sv
// Shared types for the AXI4 transaction recorder: record/pending entry
// layouts, response encodings and the response-severity helper.
package axi4_txn_pkg;

  localparam int unsigned TXN_ADDR_W = 32;
  localparam int unsigned TXN_ID_W   = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi4_resp_e;

  typedef struct packed {
    logic                  write;
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_ID_W-1:0]   id;
    logic [8:0]            beats;
    logic [1:0]            resp;
  } axi4_txn_rec_t;

  typedef struct packed {
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_ID_W-1:0]   id;
    logic [7:0]            len;
  } axi4_pend_t;

  // Worst-of two responses; the encodings are ordered by severity.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle; the recorder only attaches through the monitor modport.
interface axi4_if #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 4
);
  logic                          arvalid, arready;
  logic [AXI4_ADDRESS_WIDTH-1:0] araddr;
  logic [AXI4_ID_WIDTH-1:0]      arid;
  logic [7:0]                    arlen;

  logic                          rvalid, rready, rlast;
  logic [AXI4_DATA_WIDTH-1:0]    rdata;
  logic [AXI4_ID_WIDTH-1:0]      rid;
  logic [1:0]                    rresp;

  logic                          awvalid, awready;
  logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
  logic [AXI4_ID_WIDTH-1:0]      awid;
  logic [7:0]                    awlen;

  logic                          wvalid, wready, wlast;
  logic [AXI4_DATA_WIDTH-1:0]    wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]  wstrb;

  logic                          bvalid, bready;
  logic [AXI4_ID_WIDTH-1:0]      bid;
  logic [1:0]                    bresp;

  modport monitor (
    input arvalid, arready, araddr, arid, arlen,
    input rvalid, rready, rlast, rdata, rid, rresp,
    input awvalid, awready, awaddr, awid, awlen,
    input wvalid, wready, wlast, wdata, wstrb,
    input bvalid, bready, bid, bresp
  );
endinterface

// File: rtl/axi4_txn_pend_fifo.sv
// Small synchronous FIFO of outstanding address-phase entries.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module axi4_txn_pend_fifo
  import axi4_txn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  axi4_pend_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output axi4_pend_t head
);
  localparam int unsigned PW = $clog2(DEPTH);

  axi4_pend_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  // Status and effective push/pop qualification.
  always_comb begin
    full    = (count == (PW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi4_txn_recorder.sv
// Passive AXI4 recorder: pairs AR with R bursts and AW with B responses in
// order, and emits one completed-transaction record per burst/response.
module axi4_txn_recorder
  import axi4_txn_pkg::*;
#(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH    = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 4,
  parameter int unsigned PEND_DEPTH         = 4,
  parameter int unsigned REC_DEPTH          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  axi4_if.monitor                       monitor,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic                          rec_write,
  output logic [AXI4_ADDRESS_WIDTH-1:0] rec_addr,
  output logic [AXI4_ID_WIDTH-1:0]      rec_id,
  output logic [8:0]                    rec_beats,
  output logic [1:0]                    rec_resp,
  output logic                          pend_ovf,
  output logic                          match_err,
  output logic [15:0]                   drop_count
);
  localparam int unsigned RPW = $clog2(REC_DEPTH);

  logic          ar_hs, r_hs, aw_hs, b_hs, r_last_hs;
  axi4_pend_t    ar_entry, aw_entry, rd_head, wr_head;
  logic          rd_full, rd_empty, wr_full, wr_empty;
  logic [8:0]    beat_cnt;
  logic [1:0]    resp_acc;
  axi4_txn_rec_t rd_rec, wr_rec, out_head;
  logic          rd_rec_vld, wr_rec_vld, ovf_evt, err_evt;

  axi4_txn_rec_t rec_mem [REC_DEPTH];
  logic [RPW-1:0] rec_wp, rec_rp;
  logic [RPW:0]   rec_cnt, rec_free;
  logic           out_pop, acc_rd, acc_wr;
  logic [1:0]     n_acc, n_drop;

  logic [AXI4_DATA_WIDTH-1:0] unused_data;
  logic                       unused_misc;
  assign unused_data = monitor.rdata ^ monitor.wdata;
  assign unused_misc = ^{monitor.arlen, monitor.wvalid, monitor.wready,
                         monitor.wlast, monitor.wstrb, rd_head.len};

  // Handshake decode, pending entries, candidate records and flag events.
  always_comb begin
    ar_hs     = monitor.arvalid && monitor.arready;
    r_hs      = monitor.rvalid  && monitor.rready;
    aw_hs     = monitor.awvalid && monitor.awready;
    b_hs      = monitor.bvalid  && monitor.bready;
    r_last_hs = r_hs && monitor.rlast;

    ar_entry      = '0;
    ar_entry.addr = TXN_ADDR_W'(monitor.araddr);
    ar_entry.id   = TXN_ID_W'(monitor.arid);
    aw_entry      = '0;
    aw_entry.addr = TXN_ADDR_W'(monitor.awaddr);
    aw_entry.id   = TXN_ID_W'(monitor.awid);
    aw_entry.len  = monitor.awlen;

    rd_rec_vld   = r_last_hs && !rd_empty;
    rd_rec       = '0;
    rd_rec.addr  = rd_head.addr;
    rd_rec.id    = rd_head.id;
    rd_rec.beats = beat_cnt + 9'd1;
    rd_rec.resp  = resp_max(resp_acc, monitor.rresp);

    wr_rec_vld   = b_hs && !wr_empty;
    wr_rec       = '0;
    wr_rec.write = 1'b1;
    wr_rec.addr  = wr_head.addr;
    wr_rec.id    = wr_head.id;
    wr_rec.beats = {1'b0, wr_head.len} + 9'd1;
    wr_rec.resp  = monitor.bresp;

    // A full FIFO is never empty, so its pop always succeeds and frees a slot.
    ovf_evt = (ar_hs && rd_full && !r_last_hs) || (aw_hs && wr_full && !b_hs);
    err_evt = (r_last_hs && (rd_empty || rd_head.id != TXN_ID_W'(monitor.rid))) ||
              (b_hs && (wr_empty || wr_head.id != TXN_ID_W'(monitor.bid)));
  end

  axi4_txn_pend_fifo #(.DEPTH(PEND_DEPTH)) u_rd_pend (
    .clk(clk), .rst(rst), .push(ar_hs), .push_data(ar_entry), .pop(r_last_hs),
    .full(rd_full), .empty(rd_empty), .head(rd_head)
  );

  axi4_txn_pend_fifo #(.DEPTH(PEND_DEPTH)) u_wr_pend (
    .clk(clk), .rst(rst), .push(aw_hs), .push_data(aw_entry), .pop(b_hs),
    .full(wr_full), .empty(wr_empty), .head(wr_head)
  );

  // Read-burst beat counter and worst-response accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      resp_acc <= RESP_OKAY;
    end else if (r_hs) begin
      if (monitor.rlast) begin
        beat_cnt <= '0;
        resp_acc <= RESP_OKAY;
      end else begin
        beat_cnt <= beat_cnt + 9'd1;
        resp_acc <= resp_max(resp_acc, monitor.rresp);
      end
    end
  end

  // Sticky protocol flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_ovf  <= 1'b0;
      match_err <= 1'b0;
    end else begin
      if (ovf_evt) pend_ovf  <= 1'b1;
      if (err_evt) match_err <= 1'b1;
    end
  end

  // Output FIFO admission: read record gets the first free slot, write the next.
  always_comb begin
    out_pop  = rec_valid && rec_ready;
    rec_free = (RPW+1)'(REC_DEPTH) - rec_cnt + (RPW+1)'(out_pop);
    acc_rd   = rd_rec_vld && (rec_free != '0);
    acc_wr   = wr_rec_vld && (rec_free > (RPW+1)'(acc_rd));
    n_acc    = {1'b0, acc_rd} + {1'b0, acc_wr};
    n_drop   = {1'b0, rd_rec_vld && !acc_rd} + {1'b0, wr_rec_vld && !acc_wr};
  end

  // Output FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_wp     <= '0;
      rec_rp     <= '0;
      rec_cnt    <= '0;
      drop_count <= '0;
    end else begin
      rec_wp  <= rec_wp + RPW'(n_acc);
      if (out_pop) rec_rp <= rec_rp + RPW'(1);
      rec_cnt <= rec_cnt + (RPW+1)'(n_acc) - (RPW+1)'(out_pop);
      if (n_drop != '0) begin
        drop_count <= (drop_count > 16'hFFFF - 16'(n_drop)) ? 16'hFFFF
                                                             : drop_count + 16'(n_drop);
      end
    end
  end

  // Output FIFO storage; up to two records land in consecutive slots.
  always_ff @(posedge clk) begin
    if (acc_rd) rec_mem[rec_wp] <= rd_rec;
    if (acc_wr) rec_mem[rec_wp + RPW'(acc_rd)] <= wr_rec;
  end

  // Record stream outputs, forced to zero while the FIFO is empty.
  always_comb begin
    rec_valid = (rec_cnt != '0);
    out_head  = rec_valid ? rec_mem[rec_rp] : '0;
    rec_write = out_head.write;
    rec_addr  = AXI4_ADDRESS_WIDTH'(out_head.addr);
    rec_id    = AXI4_ID_WIDTH'(out_head.id);
    rec_beats = out_head.beats;
    rec_resp  = out_head.resp;
  end

endmodule

// File: tb/tb_axi4_txn_recorder.sv
// Self-checking bench for axi4_txn_recorder: directed table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_axi4_txn_recorder;
  import axi4_txn_pkg::*;

  localparam int unsigned PEND = 4;
  localparam int unsigned RDEP = 8;

  logic        clk = 1'b0;
  logic        rst, rec_ready;
  logic        rec_valid, rec_write, pend_ovf, match_err;
  logic [31:0] rec_addr;
  logic [3:0]  rec_id;
  logic [8:0]  rec_beats;
  logic [1:0]  rec_resp;
  logic [15:0] drop_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  axi4_if #(.AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(4)) bus ();

  axi4_txn_recorder #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(4),
    .PEND_DEPTH(PEND), .REC_DEPTH(RDEP)
  ) dut (
    .clk(clk), .rst(rst), .monitor(bus),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_write(rec_write),
    .rec_addr(rec_addr), .rec_id(rec_id), .rec_beats(rec_beats), .rec_resp(rec_resp),
    .pend_ovf(pend_ovf), .match_err(match_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  typedef struct { logic [31:0] addr; logic [3:0] id; int len; } pend_m_t;
  typedef struct { bit write; logic [31:0] addr; logic [3:0] id; int beats; int resp; } rec_m_t;

  pend_m_t rq[$];
  pend_m_t wq[$];
  rec_m_t  oq[$];
  int      m_beats, m_resp, m_drop;
  bit      m_ovf, m_err;

  task automatic put_rec(input rec_m_t r);
    if (oq.size() < RDEP) oq.push_back(r);
    else if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_step();
    pend_m_t h;
    rec_m_t  rd, wr;
    bit      has_rd, has_wr;
    int      nb, nr;
    if (rst) begin
      rq.delete(); wq.delete(); oq.delete();
      m_beats = 0; m_resp = 0; m_drop = 0; m_ovf = 0; m_err = 0;
      return;
    end
    has_rd = 0; has_wr = 0;
    if (oq.size() != 0 && rec_ready) void'(oq.pop_front());
    if (bus.rvalid && bus.rready) begin
      nb = m_beats + 1;
      nr = (int'(bus.rresp) > m_resp) ? int'(bus.rresp) : m_resp;
      if (bus.rlast) begin
        if (rq.size() == 0) m_err = 1;
        else begin
          h = rq.pop_front();
          if (h.id != bus.rid) m_err = 1;
          rd = '{1'b0, h.addr, h.id, nb, nr};
          has_rd = 1;
        end
        m_beats = 0; m_resp = 0;
      end else begin
        m_beats = nb; m_resp = nr;
      end
    end
    if (bus.bvalid && bus.bready) begin
      if (wq.size() == 0) m_err = 1;
      else begin
        h = wq.pop_front();
        if (h.id != bus.bid) m_err = 1;
        wr = '{1'b1, h.addr, h.id, h.len + 1, int'(bus.bresp)};
        has_wr = 1;
      end
    end
    if (bus.arvalid && bus.arready) begin
      if (rq.size() < PEND) rq.push_back('{bus.araddr, bus.arid, 0});
      else m_ovf = 1;
    end
    if (bus.awvalid && bus.awready) begin
      if (wq.size() < PEND) wq.push_back('{bus.awaddr, bus.awid, int'(bus.awlen)});
      else m_ovf = 1;
    end
    if (has_rd) put_rec(rd);
    if (has_wr) put_rec(wr);
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.arvalid = 0; bus.arready = 1; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.rvalid  = 0; bus.rready  = 1; bus.rlast  = 0;  bus.rdata = '0; bus.rid = '0; bus.rresp = '0;
    bus.awvalid = 0; bus.awready = 1; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
    bus.wvalid  = 0; bus.wready  = 1; bus.wlast  = 0;  bus.wdata = '0; bus.wstrb = '0;
    bus.bvalid  = 0; bus.bready  = 1; bus.bid    = '0; bus.bresp = '0;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [3:0] id);
    bus.arvalid = 1; bus.araddr = a; bus.arid = id;
  endtask

  task automatic drive_r(input logic [3:0] id, input logic [1:0] resp, input bit last);
    bus.rvalid = 1; bus.rid = id; bus.rresp = resp; bus.rlast = last; bus.rdata = $urandom;
  endtask

  task automatic drive_b(input logic [3:0] id, input logic [1:0] resp);
    bus.bvalid = 1; bus.bid = id; bus.bresp = resp;
  endtask

  task automatic do_reset();
    idle_bus();
    rec_ready = 1;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic check_model();
    chk("rnd valid", 64'(rec_valid), 64'(oq.size() != 0));
    if (oq.size() != 0) begin
      chk("rnd write", 64'(rec_write), 64'(oq[0].write));
      chk("rnd addr",  64'(rec_addr),  64'(oq[0].addr));
      chk("rnd id",    64'(rec_id),    64'(oq[0].id));
      chk("rnd beats", 64'(rec_beats), 64'(oq[0].beats));
      chk("rnd resp",  64'(rec_resp),  64'(oq[0].resp));
    end
    chk("rnd pend_ovf",   64'(pend_ovf),   64'(m_ovf));
    chk("rnd match_err",  64'(match_err),  64'(m_err));
    chk("rnd drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit ar; logic [31:0] ar_addr; logic [3:0] ar_id;
    bit aw; logic [31:0] aw_addr; logic [3:0] aw_id; logic [7:0] aw_len;
    bit r;  logic [3:0] r_id; logic [1:0] r_resp; bit r_last;
    bit b;  logic [3:0] b_id; logic [1:0] b_resp;
    bit ready;
    bit ev; bit ew; logic [31:0] eaddr; logic [3:0] eid; logic [8:0] ebeats; logic [1:0] eresp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    input bit ar, input logic [31:0] ar_addr, input logic [3:0] ar_id,
    input bit aw, input logic [31:0] aw_addr, input logic [3:0] aw_id, input logic [7:0] aw_len,
    input bit r, input logic [3:0] r_id, input logic [1:0] r_resp, input bit r_last,
    input bit b, input logic [3:0] b_id, input logic [1:0] b_resp, input bit ready,
    input bit ev, input bit ew, input logic [31:0] eaddr, input logic [3:0] eid,
    input logic [8:0] ebeats, input logic [1:0] eresp);
    vec_t v;
    v = '{ar, ar_addr, ar_id, aw, aw_addr, aw_id, aw_len, r, r_id, r_resp, r_last,
          b, b_id, b_resp, ready, ev, ew, eaddr, eid, ebeats, eresp};
    return v;
  endfunction

  initial begin
    int n;
    rst = 0;
    rec_ready = 1;
    idle_bus();

    //            ar addr       id  aw addr      id len  r id resp lst b id resp rdy  ev ew eaddr        eid beats resp
    tbl.push_back(row(1, 32'h1000, 2, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  1, 2, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  1, 2, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  1, 2, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  1, 2, 2, 1,  0, 0, 0,  1,  1, 0, 32'h1000, 2, 4, 2));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 1, 32'h2000, 1, 7,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  1, 1, 0,  0,  1, 1, 32'h2000, 1, 8, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  0,  1, 1, 32'h2000, 1, 8, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(1, 32'h3000, 3, 1, 32'h4000, 5, 3,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  1, 3, 1, 1,  1, 5, 3,  1,  1, 0, 32'h3000, 3, 1, 1));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  1, 1, 32'h4000, 5, 4, 3));
    tbl.push_back(row(0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0, 32'h0,    0, 0, 0));

    // Reset state.
    do_reset();
    chk("reset rec_valid",  64'(rec_valid),  64'(0));
    chk("reset rec_addr",   64'(rec_addr),   64'(0));
    chk("reset rec_beats",  64'(rec_beats),  64'(0));
    chk("reset pend_ovf",   64'(pend_ovf),   64'(0));
    chk("reset match_err",  64'(match_err),  64'(0));
    chk("reset drop_count", 64'(drop_count), 64'(0));

    // Directed table; W beats run every cycle and must never produce records.
    foreach (tbl[i]) begin
      idle_bus();
      bus.wvalid = 1; bus.wdata = $urandom; bus.wstrb = '1;
      if (tbl[i].ar) drive_ar(tbl[i].ar_addr, tbl[i].ar_id);
      if (tbl[i].aw) begin
        bus.awvalid = 1; bus.awaddr = tbl[i].aw_addr; bus.awid = tbl[i].aw_id; bus.awlen = tbl[i].aw_len;
      end
      if (tbl[i].r) drive_r(tbl[i].r_id, tbl[i].r_resp, tbl[i].r_last);
      if (tbl[i].b) drive_b(tbl[i].b_id, tbl[i].b_resp);
      rec_ready = tbl[i].ready;
      cycle();
      chk($sformatf("tbl[%0d] valid", i), 64'(rec_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl[%0d] write", i), 64'(rec_write), 64'(tbl[i].ew));
        chk($sformatf("tbl[%0d] addr", i),  64'(rec_addr),  64'(tbl[i].eaddr));
        chk($sformatf("tbl[%0d] id", i),    64'(rec_id),    64'(tbl[i].eid));
        chk($sformatf("tbl[%0d] beats", i), 64'(rec_beats), 64'(tbl[i].ebeats));
        chk($sformatf("tbl[%0d] resp", i),  64'(rec_resp),  64'(tbl[i].eresp));
      end
      chk($sformatf("tbl[%0d] match_err", i), 64'(match_err),  64'(0));
      chk($sformatf("tbl[%0d] drops", i),     64'(drop_count), 64'(0));
    end

    // Pending overflow: five ARs into four slots, then four completions.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_bus(); drive_ar(32'h100 * (i + 1), 4'(i)); cycle();
    end
    chk("ovf pend_ovf", 64'(pend_ovf), 64'(1));
    chk("ovf match_err", 64'(match_err), 64'(0));
    for (int i = 0; i < 4; i++) begin
      idle_bus(); drive_r(4'(i), RESP_OKAY, 1); cycle();
      chk("ovf rd valid", 64'(rec_valid), 64'(1));
      chk("ovf rd addr", 64'(rec_addr), 64'(32'h100 * (i + 1)));
    end
    idle_bus(); drive_r(4'd4, RESP_OKAY, 1); cycle();
    chk("ovf orphan match_err", 64'(match_err), 64'(1));
    chk("ovf orphan valid", 64'(rec_valid), 64'(0));

    // Output FIFO overflow with a stalled consumer, then an orphan B.
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 10; i++) begin
      idle_bus(); drive_ar(32'h8000 + 32'(i * 16), 4'(i)); cycle();
      idle_bus(); drive_r(4'(i), RESP_OKAY, 1); cycle();
    end
    chk("drop count", 64'(drop_count), 64'(2));
    chk("drop valid", 64'(rec_valid), 64'(1));
    chk("drop head addr", 64'(rec_addr), 64'(32'h8000));
    chk("drop match_err", 64'(match_err), 64'(0));
    idle_bus(); drive_b(4'd3, RESP_OKAY); cycle();
    chk("orphan b match_err", 64'(match_err), 64'(1));
    chk("orphan b drops", 64'(drop_count), 64'(2));
    idle_bus();
    rec_ready = 1;
    n = 0;
    while (rec_valid && n < 20) begin
      chk("drain addr", 64'(rec_addr), 64'(32'h8000 + 32'(n * 16)));
      n++;
      cycle();
    end
    chk("drain count", 64'(n), 64'(8));

    // Reset in the middle of a read burst.
    do_reset();
    rec_ready = 0;
    idle_bus(); drive_b(4'd0, RESP_OKAY); cycle();
    idle_bus(); drive_ar(32'h9000, 4'd1); cycle();
    idle_bus(); drive_r(4'd1, RESP_OKAY, 1); cycle();
    idle_bus(); drive_ar(32'h5000, 4'd7); cycle();
    idle_bus(); drive_r(4'd7, RESP_OKAY, 0); cycle();
    idle_bus(); drive_r(4'd7, RESP_OKAY, 0); cycle();
    chk("pre-rst valid", 64'(rec_valid), 64'(1));
    chk("pre-rst match_err", 64'(match_err), 64'(1));
    idle_bus(); rst = 1; cycle(); rst = 0;
    chk("rst valid", 64'(rec_valid), 64'(0));
    chk("rst addr", 64'(rec_addr), 64'(0));
    chk("rst match_err", 64'(match_err), 64'(0));
    chk("rst pend_ovf", 64'(pend_ovf), 64'(0));
    rec_ready = 1;
    idle_bus(); drive_r(4'd7, RESP_OKAY, 0); cycle();
    chk("post-rst beat3 match_err", 64'(match_err), 64'(0));
    idle_bus(); drive_r(4'd7, RESP_OKAY, 1); cycle();
    chk("post-rst last match_err", 64'(match_err), 64'(1));
    chk("post-rst last valid", 64'(rec_valid), 64'(0));

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_bus();
      bus.arvalid = ($urandom_range(0, 3) == 0);
      bus.arready = ($urandom_range(0, 3) != 0);
      bus.araddr  = $urandom;
      bus.arid    = 4'($urandom);
      bus.awvalid = ($urandom_range(0, 4) == 0);
      bus.awready = ($urandom_range(0, 3) != 0);
      bus.awaddr  = $urandom;
      bus.awid    = 4'($urandom);
      bus.awlen   = 8'($urandom);
      bus.wvalid  = $urandom_range(0, 1) == 1;
      bus.wdata   = $urandom;
      bus.rvalid  = ($urandom_range(0, 2) == 0);
      bus.rready  = ($urandom_range(0, 3) != 0);
      bus.rlast   = ($urandom_range(0, 2) == 0) || (m_beats >= 200);
      bus.rresp   = 2'($urandom);
      bus.rdata   = $urandom;
      bus.rid     = (rq.size() != 0 && $urandom_range(0, 7) != 0) ? rq[0].id : 4'($urandom);
      bus.bvalid  = ($urandom_range(0, 5) == 0);
      bus.bready  = ($urandom_range(0, 3) != 0);
      bus.bresp   = 2'($urandom);
      bus.bid     = (wq.size() != 0 && $urandom_range(0, 7) != 0) ? wq[0].id : 4'($urandom);
      rec_ready   = ((c % 600) < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 599) == 0);
      cycle();
      check_model();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
